instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Fetch front-end between a variable-latency instruction memory port and the decode stage.
//  Fetches sequential words ahead of the core and holds them in a small FIFO.
//  Presents {pc, instruction} pairs to decode through a valid/ready handshake.
//  Flushes and restarts on a branch/jump redirect from the PC-select logic.
// PARAMETERS
//  DEPTH     4             queue entries; power of two, >= 2
//  RESET_PC  32'h00000000  first fetch address after reset
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  rst          in   1   reset, synchronous, active-low
//  mem_req      out  1   fetch request to instruction memory
//  mem_addr     out  32  word address of request, bits[1:0]=0
//  mem_ack      in   1   request complete; mem_rdata valid this cycle
//  mem_rdata    in   32  fetched instruction word
//  out_valid    out  1   out_instr/out_pc valid
//  out_ready    in   1   decode accepts the entry; pop on valid&ready
//  out_instr    out  32  instruction at queue head
//  out_pc       out  32  address of out_instr
//  redirect     in   1   discard queue and restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch address; bits[1:0] ignored (forced 0)
//  count        out  $clog2(DEPTH)+1  current queue occupancy
// BEHAVIOUR
//  Reset (rst=0 at edge): state=S_IDLE, fetch_pc=RESET_PC, queue empty, count=0,
//   out_valid=0, mem_req=0, mem_addr=RESET_PC, out_instr=0, out_pc=0.
//  Memory protocol: at most one outstanding request. mem_req and mem_addr are
//   registered and held stable until the cycle mem_ack=1; ack completes the request
//   and mem_rdata is sampled on that edge. mem_ack while mem_req=0 is ignored.
//  FSM states:
//   S_IDLE : mem_req=0. Go to S_FETCH when count<DEPTH (first cycle after reset).
//   S_FETCH: mem_req=1, mem_addr=fetch_pc. On ack: push {fetch_pc, mem_rdata} and
//     set fetch_pc+=4. Next state S_FETCH if count_next<DEPTH, else S_IDLE.
//   S_FLUSH: mem_req=1 with the stale address (the request cannot be withdrawn).
//     On ack: discard data and go to S_FETCH at fetch_pc.
//  Space: S_FETCH is entered only with count<DEPTH, so an ack always has a free slot.
//   count_next = count + push - pop. Push and pop in the same cycle are legal at any
//   occupancy, including full.
//  Output: out_valid = (count!=0). Head entry drives out_instr/out_pc.
//   Latency from ack to out_valid is 1 cycle (queue registered).
//  Redirect has the highest priority. In the redirect cycle:
//   - queue cleared (count=0, out_valid=0 next cycle);
//   - any pop in that cycle is cancelled;
//   - fetch_pc = {redirect_pc[31:2],2'b00}.
//   Next state by current state:
//   - S_IDLE -> S_FETCH.
//   - S_FETCH with no ack -> S_FLUSH.
//   - S_FETCH with ack -> data dropped, S_FETCH at the new pc.
//   - S_FLUSH without ack -> stay S_FLUSH, fetch_pc updated again.
//   - S_FLUSH with ack -> S_FETCH at the new pc.
//  Wrap-around: fetch_pc 32'hFFFFFFFC + 4 wraps to 0. FIFO pointers wrap modulo DEPTH.
//  Reset mid-transaction: the outstanding request is abandoned (mem_req=0 next cycle).
//   The memory must tolerate a dropped request.
// CONFIGURATION
//  PREFETCH_BYPASS_EN defined:
//   - When count==0, state=S_FETCH, mem_ack=1 and redirect=0, mem_rdata and fetch_pc
//     are forwarded combinationally: out_valid=1 in the ack cycle.
//   - If out_ready=1 that cycle, the word is consumed and not pushed; otherwise it
//     is pushed normally.
//   - Ack-to-decode latency becomes 0 cycles.
//  PREFETCH_BYPASS_EN undefined: no combinational mem->out path; latency fixed at 1 cycle.
// TESTING
//  1 Reset with RESET_PC=0, mem_ack=1 every req cycle, out_ready=1 -> out_pc 0,4,8,...
//    in order; out_instr equals the memory model at that address; count never exceeds 2.
//  2 out_ready=0, memory acks every cycle -> 4 pushes; count=4; mem_req=0 and S_IDLE.
//    Then a single pop -> mem_req=1 next cycle at addr 0x10.
//  3 Request to 0x08 with a 5-cycle ack delay; redirect to 0x100 on delay cycle 2 ->
//    mem_addr stays 0x08 until ack; that word is never output; next mem_addr=0x100;
//    first out_pc=0x100.
//  4 Redirect with mem_ack in the same cycle, count=3, out_ready=1 -> no pop recorded,
//    count=0 next cycle, acked word dropped, next fetch at redirect_pc.
//  5 redirect_pc=32'hFFFFFFFE -> fetches 0xFFFFFFFC, then 0x00000000.
//  6 rst=0 for one cycle while S_FETCH with count=2 -> next cycle mem_req=0, out_valid=0,
//    count=0; first fetch at RESET_PC. With PREFETCH_BYPASS_EN, the first word appears
//    on out_instr in its ack cycle.

Source files
------------

// File: rtl/instr_prefetch_queue_if.sv
// rtl/instr_prefetch_queue_if.sv - bus bundle between the prefetch queue, instruction memory and decode
//
// Purpose: groups the memory fetch port, the decode handshake, the redirect
// input and the occupancy output of instr_prefetch_queue.
//
// Signals:
//   mem_req/mem_addr    fetch request and word address (queue -> memory)
//   mem_ack/mem_rdata   request completion and fetched word (memory -> queue)
//   out_valid/out_ready decode handshake; out_instr/out_pc carry the head entry
//   redirect/redirect_pc flush and restart fetch at a new address
//   count               current queue occupancy
//
// Modports: master = prefetch queue side, slave = memory/decode/PC-select side.

interface instr_prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] count;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc, count,
    input  mem_ack, mem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc, count,
    output mem_ack, mem_rdata, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - sequential instruction prefetcher with a small FIFO and redirect flush
//
// Purpose: fetches sequential words ahead of decode from a variable-latency
// memory port (one outstanding request), buffers {pc, instr} pairs in a
// DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
// A redirect clears the queue and restarts fetch at the new address; a
// request already in flight is completed and its data discarded.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-low reset
//   bus   instr_prefetch_queue_if.master (memory port, decode port,
//         redirect, count)
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   When defined, a word acked while the queue is empty is forwarded to
//   decode in the ack cycle (and not stored if decode takes it).

module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                   clk,
  input logic                   rst,
  instr_prefetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_next;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_pc_q    [DEPTH];
  logic [31:0]   r_instr_q [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_clear;
  logic          w_head_valid;
  logic          w_bypass;
  logic [31:0]   w_out_instr;
  logic [31:0]   w_out_pc;
  logic          w_unused_pc_lsbs;

  // An ack only counts while a request is actually outstanding.
  assign w_ack        = bus.mem_ack & r_mem_req;
  assign w_head_valid = (r_count != '0);

  // The low address bits of a redirect target are forced to zero.
  assign w_unused_pc_lsbs = ^bus.redirect_pc[1:0];

`ifdef PREFETCH_BYPASS_EN
  // Forward the word being acked when nothing older is waiting in the queue.
  assign w_bypass = (r_count == '0) && (r_state == S_FETCH) && w_ack && !bus.redirect;
`else
  assign w_bypass = 1'b0;
`endif

  // Next-state, push/pop and fetch address
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_clear         = 1'b0;

    if (bus.redirect) begin
      // Redirect wins: queue dropped, any pop this cycle cancelled.
      w_clear         = 1'b1;
      w_fetch_pc_next = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      w_pop = w_head_valid & bus.out_ready;
      if ((r_state == S_FETCH) && w_ack) begin
        w_fetch_pc_next = r_fetch_pc + 32'd4;
        // A bypassed word taken by decode this cycle is never stored.
        w_push = ~(w_bypass & bus.out_ready);
      end
    end

    w_count_next = w_clear ? '0 : (r_count + CW'(w_push) - CW'(w_pop));

    if (bus.redirect) begin
      case (r_state)
        S_IDLE:  w_state_next = S_FETCH;
        // Without an ack the old request is still in flight and must be
        // waited out in S_FLUSH; with an ack we can fetch the new pc at once.
        S_FETCH,
        S_FLUSH: w_state_next = w_ack ? S_FETCH : S_FLUSH;
        default: w_state_next = S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE:  if (w_count_next < DEPTH_C) w_state_next = S_FETCH;
        // Only keep fetching while there is a slot for the next ack.
        S_FETCH: if (w_ack) w_state_next = (w_count_next < DEPTH_C) ? S_FETCH : S_IDLE;
        S_FLUSH: if (w_ack) w_state_next = S_FETCH;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // State, request and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_mem_req  <= (w_state_next != S_IDLE);
      // In S_FLUSH the stale address is held until its ack arrives.
      if (w_state_next == S_FETCH) begin
        r_mem_addr <= w_fetch_pc_next;
      end
      r_count <= w_count_next;
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_pc_q[r_wr_ptr]    <= r_fetch_pc;
      r_instr_q[r_wr_ptr] <= bus.mem_rdata;
    end
  end

  // Head of queue, or the forwarded word when bypassing; zero when empty.
  always_comb begin
    w_out_instr = '0;
    w_out_pc    = '0;
    if (w_head_valid) begin
      w_out_instr = r_instr_q[r_rd_ptr];
      w_out_pc    = r_pc_q[r_rd_ptr];
    end else if (w_bypass) begin
      w_out_instr = bus.mem_rdata;
      w_out_pc    = r_fetch_pc;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.out_valid = w_head_valid | w_bypass;
  assign bus.out_instr = w_out_instr;
  assign bus.out_pc    = w_out_pc;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - directed scoreboard bench for instr_prefetch_queue

module tb_instr_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk;
  logic rst;

  instr_prefetch_queue_if #(.DEPTH(DEPTH)) ifc ();

  instr_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sbq[$];
  logic [31:0] addr_log[$];
  logic [31:0] exp_pc;
  bit          stale;
  int          wait_cnt;
  int          ack_delay;
  int          max_count;
  bit          last_ack;
  int          pops_mark;
  logic [31:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: memory responds, outputs are compared against the
  // scoreboard, the model advances, then the rising edge is taken.
  task automatic cycle();
    logic        ack;
    logic        exp_valid;
    logic        fetch_ok;
    logic [63:0] ent;
    ack = 1'b0;
    if (ifc.mem_req) begin
      if (wait_cnt >= ack_delay) ack = 1'b1;
      else wait_cnt++;
    end
    ifc.mem_ack   = ack;
    ifc.mem_rdata = ack ? mem_word(ifc.mem_addr) : 32'hDEAD_BEEF;
    #1;
    fetch_ok = ack && !stale;
    check("count", 32'(ifc.count), 32'(sbq.size()));
    if (fetch_ok) check("fetch_addr", ifc.mem_addr, exp_pc);
    exp_valid = (sbq.size() != 0);
    if (BYP != 0 && fetch_ok && !ifc.redirect && sbq.size() == 0) exp_valid = 1'b1;
    check("out_valid", 32'(ifc.out_valid), 32'(exp_valid));
    if (ifc.redirect) begin
      sbq.delete();
      exp_pc = {ifc.redirect_pc[31:2], 2'b00};
      stale  = ifc.mem_req && !ack;
    end else begin
      if (ack && stale) begin
        stale = 1'b0;
      end else if (fetch_ok) begin
        sbq.push_back({exp_pc, mem_word(exp_pc)});
        addr_log.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (exp_valid && ifc.out_ready && sbq.size() != 0) begin
        ent = sbq.pop_front();
        check("out_pc", ifc.out_pc, ent[63:32]);
        check("out_instr", ifc.out_instr, ent[31:0]);
        if (pops_mark == 0) first_pc = ent[63:32];
        pops_mark++;
      end
    end
    if (sbq.size() > max_count) max_count = sbq.size();
    if (ack) wait_cnt = 0;
    last_ack = ack;
    @(posedge clk);
    #1;
    ifc.mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    ifc.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    sbq.delete();
    exp_pc   = RESET_PC;
    stale    = 1'b0;
    wait_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.mem_ack     = 1'b0;
    ifc.mem_rdata   = 32'h0;
    ifc.out_ready   = 1'b0;
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = 32'h0;
    ack_delay = 0;
    max_count = 0;
    pops_mark = 0;
    first_pc  = 32'hFFFF_FFFF;
    do_reset();

    // Reset state
    check("rst_mem_req",   32'(ifc.mem_req), 32'd0);
    check("rst_mem_addr",  ifc.mem_addr, RESET_PC);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_count",     32'(ifc.count), 32'd0);
    check("rst_out_pc",    ifc.out_pc, 32'd0);
    check("rst_out_instr", ifc.out_instr, 32'd0);

    // 1: streaming with immediate acks and decode always ready
    ifc.out_ready = 1'b1;
    max_count = 0;
    pops_mark = 0;
    repeat (20) cycle();
    check("t1_max_count", 32'(max_count <= 2), 32'd1);
    check("t1_pops", 32'(pops_mark), (BYP != 0) ? 32'd19 : 32'd18);
    check("t1_first_pc", first_pc, 32'h0);

    // 2: decode stalled -> queue fills, fetch stops; one pop restarts at 0x10
    do_reset();
    ifc.out_ready = 1'b0;
    repeat (8) cycle();
    check("t2_count_full", 32'(ifc.count), 32'd4);
    check("t2_req_idle",   32'(ifc.mem_req), 32'd0);
    ifc.out_ready = 1'b1;
    cycle();
    ifc.out_ready = 1'b0;
    check("t2_req_resume", 32'(ifc.mem_req), 32'd1);
    check("t2_addr_10",    ifc.mem_addr, 32'h10);
    repeat (2) cycle();

    // 3: slow ack on 0x08, redirect to 0x100 while it is outstanding
    do_reset();
    ifc.out_ready = 1'b1;
    ack_delay = 0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.mem_req && ifc.mem_addr == 32'h8) break;
      cycle();
    end
    check("t3_reach_08", ifc.mem_addr, 32'h8);
    ack_delay = 5;
    cycle();
    cycle();
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 32'h100;
    cycle();
    ifc.redirect = 1'b0;
    last_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_addr", ifc.mem_addr, 32'h8);
      cycle();
      if (last_ack) break;
    end
    check("t3_acked", 32'(last_ack), 32'd1);
    ack_delay = 0;
    check("t3_req_new", 32'(ifc.mem_req), 32'd1);
    check("t3_addr_new", ifc.mem_addr, 32'h100);
    pops_mark = 0;
    first_pc  = 32'hFFFF_FFFF;
    repeat (5) cycle();
    check("t3_first_pc", first_pc, 32'h100);

    // 4: redirect coincides with an ack at count=3 and decode ready
    do_reset();
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.count == 3 && ifc.mem_req) break;
      cycle();
    end
    check("t4_count3", 32'(ifc.count), 32'd3);
    ifc.out_ready   = 1'b1;
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 32'h200;
    pops_mark = 0;
    cycle();
    ifc.redirect = 1'b0;
    check("t4_no_pop",     32'(pops_mark), 32'd0);
    check("t4_count0",     32'(ifc.count), 32'd0);
    check("t4_out_valid0", 32'(ifc.out_valid), 32'd0);
    check("t4_addr_new",   ifc.mem_addr, 32'h200);
    first_pc = 32'hFFFF_FFFF;
    repeat (4) cycle();
    check("t4_first_pc", first_pc, 32'h200);

    // 5: redirect target wraps through the top of the address space
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 32'hFFFF_FFFE;
    cycle();
    ifc.redirect = 1'b0;
    addr_log.delete();
    repeat (6) cycle();
    check("t5_log_len", 32'(addr_log.size() >= 2), 32'd1);
    if (addr_log.size() >= 2) begin
      check("t5_fetch0", addr_log[0], 32'hFFFF_FFFC);
      check("t5_fetch1", addr_log[1], 32'h0000_0000);
    end

    // 6: reset while fetching with two entries queued
    do_reset();
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.count == 2 && ifc.mem_req) break;
      cycle();
    end
    check("t6_count2", 32'(ifc.count), 32'd2);
    do_reset();
    check("t6_req0",   32'(ifc.mem_req), 32'd0);
    check("t6_valid0", 32'(ifc.out_valid), 32'd0);
    check("t6_count0", 32'(ifc.count), 32'd0);
    ifc.out_ready = 1'b1;
    pops_mark = 0;
    first_pc  = 32'hFFFF_FFFF;
    cycle();
    cycle();
    check("t6_ack_cycle_pops", 32'(pops_mark), (BYP != 0) ? 32'd1 : 32'd0);
    cycle();
    check("t6_first_pc", first_pc, RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
